// File: rtl/exmem_pipe.sv
// EX/MEM pipeline register: captures execute-stage results and control,
// with stall, flush, a halt sequence (one-cycle data-memory dump then
// freeze) and a count of valid instructions entering MEM.
module exmem_pipe (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ALUResultIn,
    input  logic [15:0] ReadData2In,
    input  logic [2:0]  ALUFlagsIn,
    input  logic [2:0]  WriteRegIn,
    input  logic [2:0]  SetSelectIn,
    input  logic        RegWriteIn,
    input  logic        MemToRegIn,
    input  logic        DMemWriteIn,
    input  logic        DMemEnIn,
    input  logic        HaltIn,
    input  logic        ValidIn,
    input  logic        Stall,
    input  logic        Flush,
    output logic [15:0] ALUResult,
    output logic [15:0] ReadData2,
    output logic [2:0]  ALUFlags,
    output logic [2:0]  WriteReg,
    output logic [2:0]  SetSelect,
    output logic        RegWrite,
    output logic        MemToReg,
    output logic        DMemWrite,
    output logic        DMemEn,
    output logic        DMemDump,
    output logic        Halted,
    output logic        FreezeUp,
    output logic [15:0] InstrCount
);

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    state_t      state;
    state_t      nextState;

    logic [15:0] aluResult;
    logic [15:0] readData2;
    logic [2:0]  aluFlags;
    logic [2:0]  writeReg;
    logic [2:0]  setSelect;
    logic        regWrite;
    logic        memToReg;
    logic        dMemWrite;
    logic        dMemEn;
    logic        halt;
    logic        v;
    logic [15:0] count;

    logic        live;
    logic        dump;

    // State register; only reset leaves HALTED
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= RUN;
        end else begin
            state <= nextState;
        end
    end

    // Next state: a valid halt sitting in MEM freezes the pipe on the next
    // edge, regardless of Stall, since the halt has already been accepted
    always_comb begin
        nextState = state;
        if (state == RUN && v && halt) begin
            nextState = HALTED;
        end
    end

    // Pipeline register and instruction counter: HALTED > Flush > Stall > load
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            aluResult <= '0;
            readData2 <= '0;
            aluFlags  <= '0;
            writeReg  <= '0;
            setSelect <= '0;
            regWrite  <= 1'b0;
            memToReg  <= 1'b0;
            dMemWrite <= 1'b0;
            dMemEn    <= 1'b0;
            halt      <= 1'b0;
            v         <= 1'b0;
            count     <= '0;
        end else if (state == HALTED) begin
            // frozen: hold everything
        end else if (Flush) begin
            v         <= 1'b0;
            regWrite  <= 1'b0;
            memToReg  <= 1'b0;
            dMemWrite <= 1'b0;
            dMemEn    <= 1'b0;
            halt      <= 1'b0;
        end else if (!Stall) begin
            aluResult <= ALUResultIn;
            readData2 <= ReadData2In;
            aluFlags  <= ALUFlagsIn;
            writeReg  <= WriteRegIn;
            setSelect <= SetSelectIn;
            regWrite  <= RegWriteIn;
            memToReg  <= MemToRegIn;
            dMemWrite <= DMemWriteIn;
            dMemEn    <= DMemEnIn;
            halt      <= HaltIn;
            v         <= ValidIn;
            if (ValidIn) begin
                count <= count + 16'd1;
            end
        end
    end

    // Output gating: control only acts for a valid instruction while running;
    // the dump cycle suppresses normal data-memory access
    always_comb begin
        live       = v & (state == RUN);
        dump       = live & halt;
        ALUResult  = aluResult;
        ReadData2  = readData2;
        ALUFlags   = aluFlags;
        WriteReg   = writeReg;
        SetSelect  = setSelect;
        RegWrite   = regWrite & live;
        MemToReg   = memToReg & live;
        DMemWrite  = dMemWrite & live & ~dump;
        DMemEn     = dMemEn & live & ~dump;
        DMemDump   = dump;
        Halted     = (state == HALTED);
        FreezeUp   = (state == HALTED);
        InstrCount = count;
    end

endmodule

// File: tb/tb_exmem_pipe.sv
// Directed self-checking bench for exmem_pipe.
module tb_exmem_pipe;

    logic        clk;
    logic        rst;
    logic [15:0] ALUResultIn;
    logic [15:0] ReadData2In;
    logic [2:0]  ALUFlagsIn;
    logic [2:0]  WriteRegIn;
    logic [2:0]  SetSelectIn;
    logic        RegWriteIn;
    logic        MemToRegIn;
    logic        DMemWriteIn;
    logic        DMemEnIn;
    logic        HaltIn;
    logic        ValidIn;
    logic        Stall;
    logic        Flush;
    logic [15:0] ALUResult;
    logic [15:0] ReadData2;
    logic [2:0]  ALUFlags;
    logic [2:0]  WriteReg;
    logic [2:0]  SetSelect;
    logic        RegWrite;
    logic        MemToReg;
    logic        DMemWrite;
    logic        DMemEn;
    logic        DMemDump;
    logic        Halted;
    logic        FreezeUp;
    logic [15:0] InstrCount;

    int total;
    int bad;

    exmem_pipe dut (
        .clk(clk), .rst(rst),
        .ALUResultIn(ALUResultIn), .ReadData2In(ReadData2In),
        .ALUFlagsIn(ALUFlagsIn), .WriteRegIn(WriteRegIn), .SetSelectIn(SetSelectIn),
        .RegWriteIn(RegWriteIn), .MemToRegIn(MemToRegIn), .DMemWriteIn(DMemWriteIn),
        .DMemEnIn(DMemEnIn), .HaltIn(HaltIn), .ValidIn(ValidIn),
        .Stall(Stall), .Flush(Flush),
        .ALUResult(ALUResult), .ReadData2(ReadData2), .ALUFlags(ALUFlags),
        .WriteReg(WriteReg), .SetSelect(SetSelect), .RegWrite(RegWrite),
        .MemToReg(MemToReg), .DMemWrite(DMemWrite), .DMemEn(DMemEn),
        .DMemDump(DMemDump), .Halted(Halted), .FreezeUp(FreezeUp),
        .InstrCount(InstrCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance one rising edge, then settle 1 ns before sampling/driving
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        ALUResultIn = '0; ReadData2In = '0; ALUFlagsIn = '0; WriteRegIn = '0;
        SetSelectIn = '0; RegWriteIn = 0; MemToRegIn = 0; DMemWriteIn = 0;
        DMemEnIn = 0; HaltIn = 0; ValidIn = 0; Stall = 0; Flush = 0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        clearInputs();
        step();
        step();
        total++; if (ALUResult !== 16'h0000) begin bad++; $display("FAIL reset_alu got=%h exp=0000", ALUResult); end
        total++; if (ReadData2 !== 16'h0000) begin bad++; $display("FAIL reset_rd2 got=%h exp=0000", ReadData2); end
        total++; if ({ALUFlags, WriteReg, SetSelect} !== 9'd0) begin bad++; $display("FAIL reset_fields got=%b exp=0", {ALUFlags, WriteReg, SetSelect}); end
        total++; if ({RegWrite, MemToReg, DMemWrite, DMemEn, DMemDump, Halted, FreezeUp} !== 7'd0) begin
            bad++; $display("FAIL reset_ctrl got=%b exp=0000000", {RegWrite, MemToReg, DMemWrite, DMemEn, DMemDump, Halted, FreezeUp});
        end
        total++; if (InstrCount !== 16'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", InstrCount); end
        rst = 1'b1;
    endtask

    task automatic test_load();
        ALUResultIn = 16'h0029; WriteRegIn = 3'b011; RegWriteIn = 1; ValidIn = 1;
        ReadData2In = 16'h00A5; ALUFlagsIn = 3'b101; SetSelectIn = 3'b100;
        step();
        total++; if (ALUResult !== 16'h0029) begin bad++; $display("FAIL load_alu got=%h exp=0029", ALUResult); end
        total++; if (WriteReg !== 3'd3) begin bad++; $display("FAIL load_wreg got=%0d exp=3", WriteReg); end
        total++; if (RegWrite !== 1'b1) begin bad++; $display("FAIL load_regwrite got=%b exp=1", RegWrite); end
        total++; if (InstrCount !== 16'd1) begin bad++; $display("FAIL load_count got=%0d exp=1", InstrCount); end
        total++; if (ReadData2 !== 16'h00A5) begin bad++; $display("FAIL load_rd2 got=%h exp=00a5", ReadData2); end
        total++; if ({ALUFlags, SetSelect} !== 6'b101100) begin bad++; $display("FAIL load_flags_set got=%b exp=101100", {ALUFlags, SetSelect}); end
    endtask

    task automatic test_stall();
        clearInputs();
        ALUResultIn = 16'h0032; RegWriteIn = 1; ValidIn = 1;
        step();
        total++; if (ALUResult !== 16'h0032) begin bad++; $display("FAIL stall_pre_alu got=%h exp=0032", ALUResult); end
        total++; if (InstrCount !== 16'd2) begin bad++; $display("FAIL stall_pre_count got=%0d exp=2", InstrCount); end
        Stall = 1; ALUResultIn = 16'h1234;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (ALUResult !== 16'h0032) begin bad++; $display("FAIL stall_hold_alu[%0d] got=%h exp=0032", i, ALUResult); end
            total++; if (InstrCount !== 16'd2) begin bad++; $display("FAIL stall_hold_count[%0d] got=%0d exp=2", i, InstrCount); end
        end
        Stall = 0;
    endtask

    task automatic test_flush_stall();
        clearInputs();
        ALUResultIn = 16'h0040; DMemWriteIn = 1; DMemEnIn = 1; RegWriteIn = 1; ValidIn = 1;
        step();
        total++; if ({DMemWrite, DMemEn} !== 2'b11) begin bad++; $display("FAIL flush_pre got=%b exp=11", {DMemWrite, DMemEn}); end
        total++; if (InstrCount !== 16'd3) begin bad++; $display("FAIL flush_pre_count got=%0d exp=3", InstrCount); end
        Flush = 1; Stall = 1;
        step();
        total++; if ({DMemWrite, DMemEn, RegWrite} !== 3'b000) begin bad++; $display("FAIL flush_ctrl got=%b exp=000", {DMemWrite, DMemEn, RegWrite}); end
        total++; if (InstrCount !== 16'd3) begin bad++; $display("FAIL flush_count got=%0d exp=3", InstrCount); end
        Flush = 0; Stall = 0;
    endtask

    task automatic test_bubble();
        clearInputs();
        ALUResultIn = 16'h0055; RegWriteIn = 1; DMemEnIn = 1; ValidIn = 0;
        step();
        total++; if ({RegWrite, DMemEn} !== 2'b00) begin bad++; $display("FAIL bubble_ctrl got=%b exp=00", {RegWrite, DMemEn}); end
        total++; if (InstrCount !== 16'd3) begin bad++; $display("FAIL bubble_count got=%0d exp=3", InstrCount); end
        total++; if (ALUResult !== 16'h0055) begin bad++; $display("FAIL bubble_data got=%h exp=0055", ALUResult); end
    endtask

    task automatic test_halt();
        clearInputs();
        ALUResultIn = 16'h0066; HaltIn = 1; ValidIn = 1; DMemEnIn = 1;
        step();
        total++; if ({DMemDump, DMemEn, Halted} !== 3'b100) begin bad++; $display("FAIL halt_dump got=%b exp=100", {DMemDump, DMemEn, Halted}); end
        total++; if (InstrCount !== 16'd4) begin bad++; $display("FAIL halt_count got=%0d exp=4", InstrCount); end
        HaltIn = 0; ValidIn = 0; DMemEnIn = 0;
        step();
        total++; if ({DMemDump, Halted, FreezeUp, DMemEn} !== 4'b0110) begin
            bad++; $display("FAIL halt_enter got=%b exp=0110", {DMemDump, Halted, FreezeUp, DMemEn});
        end
        total++; if (ALUResult !== 16'h0066) begin bad++; $display("FAIL halt_enter_alu got=%h exp=0066", ALUResult); end
        ALUResultIn = 16'hBEEF; ValidIn = 1; RegWriteIn = 1; HaltIn = 1; DMemEnIn = 1; DMemWriteIn = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (ALUResult !== 16'h0066) begin bad++; $display("FAIL halted_alu[%0d] got=%h exp=0066", i, ALUResult); end
            total++; if (InstrCount !== 16'd4) begin bad++; $display("FAIL halted_count[%0d] got=%0d exp=4", i, InstrCount); end
            total++; if ({Halted, FreezeUp, DMemDump, RegWrite, DMemEn, DMemWrite} !== 6'b110000) begin
                bad++; $display("FAIL halted_ctrl[%0d] got=%b exp=110000", i, {Halted, FreezeUp, DMemDump, RegWrite, DMemEn, DMemWrite});
            end
        end
    endtask

    task automatic test_reset_midhalt();
        #3;
        rst = 1'b0;
        #1;
        total++; if ({Halted, FreezeUp} !== 2'b00) begin bad++; $display("FAIL midrst_halted got=%b exp=00", {Halted, FreezeUp}); end
        total++; if (InstrCount !== 16'd0) begin bad++; $display("FAIL midrst_count got=%0d exp=0", InstrCount); end
        total++; if (ALUResult !== 16'h0000) begin bad++; $display("FAIL midrst_alu got=%h exp=0000", ALUResult); end
        #2;
        rst = 1'b1;
        clearInputs();
        ALUResultIn = 16'h0077; ValidIn = 1; RegWriteIn = 1;
        step();
        total++; if (ALUResult !== 16'h0077) begin bad++; $display("FAIL postrst_alu got=%h exp=0077", ALUResult); end
        total++; if ({RegWrite, Halted} !== 2'b10) begin bad++; $display("FAIL postrst_ctrl got=%b exp=10", {RegWrite, Halted}); end
        total++; if (InstrCount !== 16'd1) begin bad++; $display("FAIL postrst_count got=%0d exp=1", InstrCount); end
    endtask

    task automatic test_stall_halt();
        clearInputs();
        ALUResultIn = 16'h0088; HaltIn = 1; ValidIn = 1;
        step();
        total++; if (DMemDump !== 1'b1) begin bad++; $display("FAIL sthalt_dump got=%b exp=1", DMemDump); end
        total++; if (InstrCount !== 16'd2) begin bad++; $display("FAIL sthalt_count got=%0d exp=2", InstrCount); end
        Stall = 1;
        step();
        total++; if ({Halted, DMemDump} !== 2'b10) begin bad++; $display("FAIL sthalt_enter got=%b exp=10", {Halted, DMemDump}); end
        Stall = 0;
        step();
        total++; if ({Halted, DMemDump} !== 2'b10) begin bad++; $display("FAIL sthalt_stay got=%b exp=10", {Halted, DMemDump}); end
        total++; if (InstrCount !== 16'd2) begin bad++; $display("FAIL sthalt_count2 got=%0d exp=2", InstrCount); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_load();
        test_stall();
        test_flush_stall();
        test_bubble();
        test_halt();
        test_reset_midhalt();
        test_stall_halt();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exmem_pipe.md
# exmem_pipe

EX/MEM pipeline register for the five-stage core. Captures the execute-stage results and control each cycle and presents them to `stageMemory` as its inputs. Supports stall (hold), flush (bubble insertion), a halt sequence that issues the one-cycle data-memory dump and then freezes the pipe, and a count of instructions that have entered MEM.

## Interface
Parameters
- none; the datapath is fixed at 16 bits, register IDs at 3 bits.

Ports (clock and reset first)
- `clk`  in  1  single system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset (asserted when 0).
- `ALUResultIn`  in  16  ALU result from execute.
- `ReadData2In`  in  16  store data (register file read port 2).
- `ALUFlagsIn`  in  3  {sign/carry, overflow, zero} flags from execute.
- `WriteRegIn`  in  3  destination register.
- `SetSelectIn`  in  3  set-instruction select; bit 2 = set-op.
- `RegWriteIn`, `MemToRegIn`, `DMemWriteIn`, `DMemEnIn`, `HaltIn`  in  1 each  decoded control.
- `ValidIn`  in  1  execute stage holds a real instruction.
- `Stall`  in  1  hold the current contents.
- `Flush`  in  1  replace the incoming instruction with a bubble.
- `ALUResult`, `ReadData2`  out  16  registered data for `stageMemory`.
- `ALUFlags`, `WriteReg`, `SetSelect`  out  3  registered.
- `RegWrite`, `MemToReg`, `DMemWrite`, `DMemEn`  out  1  registered control, gated by valid.
- `DMemDump`  out  1  one-cycle dump strobe for data memory.
- `Halted`  out  1  pipe frozen after a halt.
- `FreezeUp`  out  1  upstream must hold; equals `Halted`.
- `InstrCount`  out  16  count of valid instructions loaded.

## Operation
- Internal state: a data/control register set, a valid bit `V`, FSM state {RUN, HALTED}, and a 16-bit counter.
- Per-edge update priority: reset > HALTED (freeze everything) > Flush (V←0, control regs←0) > Stall (hold all) > load (all regs←inputs, V←ValidIn).
- `Flush` and `Stall` both asserted: flush wins.
- Output gating: `RegWrite`, `DMemWrite`, `DMemEn` = stored value AND `V` AND (state==RUN). Data outputs show stored values regardless of `V`.
- `DMemDump` = `V` & stored Halt & state==RUN. It is combinational from registers, and `DMemWrite`/`DMemEn` are forced to 0 in that cycle.
- FSM: RUN→HALTED on the edge where `V` & stored Halt. HALTED is left only by reset.
- In HALTED: `Halted`=`FreezeUp`=1, the gated control outputs are 0, `DMemDump`=0, and the registers and counter are frozen.
- Counter: increments by 1 on each load edge with `ValidIn`=1, including a halt instruction. No increment on stall, flush, or HALTED. It wraps 16'hFFFF→0.
- Widths pass through unchanged; there is no arithmetic on data.

## Timing
- Latency: an input accepted at edge N is visible at the outputs after edge N (1 cycle).
- Reset value of every output: all data 0, `WriteReg`=0, `SetSelect`=0, all control 0, `DMemDump`=0, `Halted`=0, `FreezeUp`=0, `InstrCount`=0, state RUN, `V`=0.
- Reset asserted mid-operation: outputs clear immediately without waiting for a clock. This includes mid-halt.
- Halt sequence: halt loaded at edge N → `DMemDump`=1 for cycle N..N+1 → edge N+1 enters HALTED → `DMemDump` is exactly one cycle wide.
- Stall during a halt-in-MEM cycle: the FSM still advances (the halt is already in MEM). `DMemDump` is not repeated.
- Flush does not affect the counter value already accumulated.

## Test plan
- Reset/load: hold `rst`=0 and check all outputs are 0. Release, drive ALUResultIn=16'h0029, WriteRegIn=3'b011, RegWriteIn=1, ValidIn=1. After one edge: ALUResult=16'h0029, WriteReg=3, RegWrite=1, InstrCount=1.
- Stall: load ALUResultIn=16'h0032, then assert Stall with ALUResultIn=16'h1234 for 3 edges. Required: ALUResult stays 16'h0032 and InstrCount does not change.
- Flush with stall: loaded DMemWrite=1, DMemEn=1, then Flush=Stall=1 for one edge. Required: DMemWrite=0, DMemEn=0, RegWrite=0, and InstrCount unchanged.
- Bubble gating: ValidIn=0 with RegWriteIn=1, DMemEnIn=1. Required: RegWrite=0, DMemEn=0, and the count does not increment.
- Halt: load HaltIn=1, ValidIn=1, DMemEnIn=1. Required: DMemDump=1 and DMemEn=0 for exactly one cycle, then Halted=FreezeUp=1. Further inputs (ALUResultIn=16'hBEEF) do not change any output. Count = previous+1.
- Async reset mid-halt: in HALTED, drop `rst` between edges. Required: Halted=0 and InstrCount=0 immediately; after release, a normal load works.
